// File: rtl/pipe_cla_add_sub.sv
// Pipelined carry-lookahead adder/subtractor: W bits split into STAGES carry-registered segments.
// Optional signed output saturation is enabled by defining PIPE_CLA_SAT_EN.

module pipe_cla_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           c_i,
  output logic [SEG-1:0] s_o,
  output logic           c_o
);
  localparam int NG = (SEG + 3) / 4;
  localparam int SP = NG * 4;

  logic [SP-1:0] a_p, b_p, g, p, bc, s_p;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;
  logic [SP:0]   full;
  logic          t_c, t_pp;

  assign a_p = SP'(a_i);
  assign b_p = SP'(b_i);
  assign g   = a_p & b_p;
  assign p   = a_p ^ b_p;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      assign gg[gi] = g[4*gi+3]
                    | (p[4*gi+3] & g[4*gi+2])
                    | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                    | ((&p[4*gi+1 +: 3]) & g[4*gi]);
      assign gp[gi] = &p[4*gi +: 4];

      assign bc[4*gi]   = gc[gi];
      assign bc[4*gi+1] = g[4*gi] | (p[4*gi] & gc[gi]);
      assign bc[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi])
                        | (p[4*gi+1] & p[4*gi] & gc[gi]);
      assign bc[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & g[4*gi+1])
                        | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                        | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & gc[gi]);
    end
  endgenerate

  // Group carries are fully flattened lookahead terms, not a group-level ripple.
  always_comb begin
    gc    = '0;
    t_c   = 1'b0;
    t_pp  = 1'b0;
    gc[0] = c_i;
    for (int j = 0; j < NG; j++) begin
      t_c  = gg[j];
      t_pp = gp[j];
      for (int i = j - 1; i >= 0; i--) begin
        t_c  = t_c | (t_pp & gg[i]);
        t_pp = t_pp & gp[i];
      end
      gc[j+1] = t_c | (t_pp & c_i);
    end
  end

  assign s_p  = p ^ bc;
  assign full = {gc[NG], s_p};
  assign s_o  = s_p[SEG-1:0];
  // Pad bits are zero, so the carry out of bit SEG-1 is the only bit that can be set above it.
  assign c_o  = |(full >> SEG);
endmodule

module pipe_cla_add_sub #(
  parameter int W      = 106,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         sub_i,
  input  logic         cin_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_o,
  output logic         cout_o,
  output logic         v_o
);
  localparam int SEG = (W + STAGES - 1) / STAGES;
  localparam int WP  = SEG * STAGES;
  localparam int PR  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int L   = STAGES - 1;

  // Stage inputs (_a): index 0 comes from the ports, index k from stage register k-1.
  logic [WP-1:0] x_a   [STAGES];
  logic [WP-1:0] yn_a  [STAGES];
  logic [WP-1:0] s_a   [STAGES];
  logic          c_a   [STAGES];
  logic          sub_a [STAGES];
  logic          vld_a [STAGES];
  logic [WP-1:0] s_d   [STAGES];
  logic          c_d   [STAGES];

  logic [WP-1:0] x_q   [PR];
  logic [WP-1:0] yn_q  [PR];
  logic [WP-1:0] s_q   [PR];
  logic          c_q   [PR];
  logic          sub_q [PR];
  logic          vld_q [PR];

  logic         adv;
  logic         raw_carry, msb_cin;
  logic [W-1:0] out_d, out_q;
  logic         cout_d, cout_q, v_d, v_q;
  logic         out_valid_q;

  assign adv         = ~out_valid_q | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign cout_o      = cout_q;
  assign v_o         = v_q;

  assign x_a[0]   = WP'(x_i);
  assign yn_a[0]  = WP'(y_i ^ {W{sub_i}});
  assign s_a[0]   = '0;
  assign c_a[0]   = sub_i | cin_i;
  assign sub_a[0] = sub_i;
  assign vld_a[0] = in_valid_i;

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_link
      assign x_a[gi]   = x_q[gi-1];
      assign yn_a[gi]  = yn_q[gi-1];
      assign s_a[gi]   = s_q[gi-1];
      assign c_a[gi]   = c_q[gi-1];
      assign sub_a[gi] = sub_q[gi-1];
      assign vld_a[gi] = vld_q[gi-1];
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
      logic [SEG-1:0] sum;
      logic           co;

      pipe_cla_seg #(.SEG(SEG)) u_cla (
        .a_i (x_a[gi][gi*SEG +: SEG]),
        .b_i (yn_a[gi][gi*SEG +: SEG]),
        .c_i (c_a[gi]),
        .s_o (sum),
        .c_o (co)
      );

      assign s_d[gi] = s_a[gi] | (WP'(sum) << (gi * SEG));
      assign c_d[gi] = co;
    end
  endgenerate

  // Final stage: the full padded sum is known, so flags and saturation are formed here.
  always_comb begin
    raw_carry = |({c_d[L], s_d[L]} >> W);
    msb_cin   = s_d[L][W-1] ^ x_a[L][W-1] ^ yn_a[L][W-1];
    v_d       = msb_cin ^ raw_carry;
    cout_d    = raw_carry ^ sub_a[L];
    out_d     = s_d[L][W-1:0];
`ifdef PIPE_CLA_SAT_EN
    if (v_d) begin
      out_d = s_d[L][W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PR; k++) begin
        x_q[k]   <= '0;
        yn_q[k]  <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        vld_q[k] <= 1'b0;
      end
      out_q       <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        x_q[k]   <= x_a[k];
        yn_q[k]  <= yn_a[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        sub_q[k] <= sub_a[k];
        vld_q[k] <= vld_a[k];
      end
      out_q       <= out_d;
      cout_q      <= cout_d;
      v_q         <= v_d;
      out_valid_q <= vld_a[L];
    end
  end
endmodule

// File: tb/tb_pipe_cla_add_sub.sv
// Bench for pipe_cla_add_sub: directed W=16/STAGES=4 checks plus random W=106/STAGES=3 stream.
// Honours PIPE_CLA_SAT_EN in its reference model.

module tb_pipe_cla_add_sub;
  typedef struct {
    logic [127:0] o;
    logic         co;
    logic         v;
    int           acc;
  } exp_t;

  logic clk, rst;

  logic        a_iv, a_ir, a_sub, a_cin, a_ov, a_or, a_co, a_v;
  logic [15:0] a_x, a_y, a_out;
  logic         b_iv, b_ir, b_sub, b_cin, b_ov, b_or, b_co, b_v;
  logic [105:0] b_x, b_y, b_out;

  int   total, bad, cyc, a_pops, b_pops;
  exp_t qa[$];
  exp_t qb[$];
  bit   lat_chk;
  bit   a_stalled, b_stalled;
  logic [15:0]  a_hold, last_out;
  logic [105:0] b_hold;
  logic         last_co, last_v;

  pipe_cla_add_sub #(.W(16), .STAGES(4)) u_a (
    .clk(clk), .rst(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .sub_i(a_sub), .cin_i(a_cin),
    .x_i(a_x), .y_i(a_y), .out_valid_o(a_ov), .out_ready_i(a_or), .out_o(a_out),
    .cout_o(a_co), .v_o(a_v)
  );

  pipe_cla_add_sub #(.W(106), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .sub_i(b_sub), .cin_i(b_cin),
    .x_i(b_x), .y_i(b_y), .out_valid_o(b_ov), .out_ready_i(b_or), .out_o(b_out),
    .cout_o(b_co), .v_o(b_v)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_calc(input int w, input logic [127:0] x, input logic [127:0] y,
                                   input logic sb, input logic ci, output logic [127:0] o,
                                   output logic co, output logic ov);
    logic signed [131:0] ux, uy, xs, ys, cs, modv, half, uns, ideal, res;
    ux    = $signed({4'b0, x});
    uy    = $signed({4'b0, y});
    cs    = $signed({131'b0, ci});
    modv  = 132'sd1 <<< w;
    half  = modv >>> 1;
    xs    = x[w-1] ? ux - modv : ux;
    ys    = y[w-1] ? uy - modv : uy;
    uns   = sb ? ux - uy : ux + uy + cs;
    ideal = sb ? xs - ys : xs + ys + cs;
    co    = sb ? (ux < uy) : (uns >= modv);
    ov    = (ideal >= half) || (ideal < -half);
    res   = uns & (modv - 132'sd1);
`ifdef PIPE_CLA_SAT_EN
    if (ov) res = (ideal > 0) ? half - 132'sd1 : half;
`endif
    o = res[127:0];
  endfunction

  task automatic a_step(input logic iv, input logic sb, input logic ci,
                        input logic [15:0] x, input logic [15:0] y, input logic ordy);
    exp_t e;
    logic [127:0] o;
    logic co, vv;
    a_iv = iv; a_sub = sb; a_cin = ci; a_x = x; a_y = y; a_or = ordy;
    #1;
    if (a_stalled) begin
      total++;
      assert (a_out === a_hold) else begin bad++; $error("FAIL a_hold_out got=%h exp=%h", a_out, a_hold); end
      total++;
      assert (a_ov === 1'b1) else begin bad++; $error("FAIL a_hold_valid got=%b exp=1", a_ov); end
    end
    total++;
    assert (a_ir === (!a_ov || ordy)) else begin bad++; $error("FAIL a_in_ready got=%b exp=%b", a_ir, !a_ov || ordy); end
    if (a_ov && ordy) begin
      total++;
      assert ((qa.size() > 0) === 1'b1) else begin bad++; $error("FAIL a_stale_beat got=%h exp=none", a_out); end
      if (qa.size() > 0) begin
        e = qa.pop_front();
        a_pops++;
        total++;
        assert (a_out === e.o[15:0]) else begin bad++; $error("FAIL a_out got=%h exp=%h", a_out, e.o[15:0]); end
        total++;
        assert (a_co === e.co) else begin bad++; $error("FAIL a_cout got=%b exp=%b", a_co, e.co); end
        total++;
        assert (a_v === e.v) else begin bad++; $error("FAIL a_v got=%b exp=%b", a_v, e.v); end
        if (lat_chk) begin
          total++;
          assert ((cyc - e.acc) === 4) else begin bad++; $error("FAIL a_latency got=%0d exp=4", cyc - e.acc); end
        end
        last_out = a_out; last_co = a_co; last_v = a_v;
      end
    end
    a_stalled = a_ov && !ordy;
    a_hold    = a_out;
    if (iv && a_ir) begin
      ref_calc(16, {112'b0, x}, {112'b0, y}, sb, ci, o, co, vv);
      e.o = o; e.co = co; e.v = vv; e.acc = cyc;
      qa.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic b_step(input logic iv, input logic sb, input logic ci,
                        input logic [105:0] x, input logic [105:0] y, input logic ordy);
    exp_t e;
    logic [127:0] o;
    logic co, vv;
    b_iv = iv; b_sub = sb; b_cin = ci; b_x = x; b_y = y; b_or = ordy;
    #1;
    if (b_stalled) begin
      total++;
      assert (b_out === b_hold) else begin bad++; $error("FAIL b_hold_out got=%h exp=%h", b_out, b_hold); end
    end
    total++;
    assert (b_ir === (!b_ov || ordy)) else begin bad++; $error("FAIL b_in_ready got=%b exp=%b", b_ir, !b_ov || ordy); end
    if (b_ov && ordy) begin
      total++;
      assert ((qb.size() > 0) === 1'b1) else begin bad++; $error("FAIL b_stale_beat got=%h exp=none", b_out); end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        b_pops++;
        total++;
        assert (b_out === e.o[105:0]) else begin bad++; $error("FAIL b_out got=%h exp=%h", b_out, e.o[105:0]); end
        total++;
        assert (b_co === e.co) else begin bad++; $error("FAIL b_cout got=%b exp=%b", b_co, e.co); end
        total++;
        assert (b_v === e.v) else begin bad++; $error("FAIL b_v got=%b exp=%b", b_v, e.v); end
      end
    end
    b_stalled = b_ov && !ordy;
    b_hold    = b_out;
    if (iv && b_ir) begin
      ref_calc(106, {22'b0, x}, {22'b0, y}, sb, ci, o, co, vv);
      e.o = o; e.co = co; e.v = vv; e.acc = cyc;
      qb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [105:0] rand106();
    logic [127:0] r;
    logic [105:0] ones;
    ones = '1;
    case ($urandom_range(0, 15))
      0: return ones;
      1: return 106'd1 << 105;
      2: return ones >> 1;
      3: return '0;
      default: begin
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[105:0];
      end
    endcase
  endfunction

  initial begin
    int p0;
    logic [15:0] exp_sub;
    total = 0; bad = 0; cyc = 0; a_pops = 0; b_pops = 0;
    lat_chk = 1'b0; a_stalled = 1'b0; b_stalled = 1'b0;
    a_hold = '0; b_hold = '0; last_out = '0; last_co = 1'b0; last_v = 1'b0;
    clk = 1'b0; rst = 1'b0;
    a_iv = 0; a_sub = 0; a_cin = 0; a_x = '0; a_y = '0; a_or = 1;
    b_iv = 0; b_sub = 0; b_cin = 0; b_x = '0; b_y = '0; b_or = 1;

    // Reset state
    #1 rst = 1'b1;
    #1;
    total++; assert (a_ov === 1'b0) else begin bad++; $error("FAIL rst_valid got=%b exp=0", a_ov); end
    total++; assert (a_out === 16'h0000) else begin bad++; $error("FAIL rst_out got=%h exp=0000", a_out); end
    total++; assert ({a_co, a_v} === 2'b00) else begin bad++; $error("FAIL rst_flags got=%b exp=00", {a_co, a_v}); end
    total++; assert (b_ov === 1'b0) else begin bad++; $error("FAIL rst_b_valid got=%b exp=0", b_ov); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; assert (a_ir === 1'b1) else begin bad++; $error("FAIL rst_in_ready got=%b exp=1", a_ir); end

    // Add with carry chain
    lat_chk = 1'b1;
    a_step(1, 0, 0, 16'hFFFF, 16'h0001, 1);
    for (int i = 0; i < 5; i++) a_step(0, 0, 0, 16'h0, 16'h0, 1);
    total++; assert (a_pops === 1) else begin bad++; $error("FAIL add_count got=%0d exp=1", a_pops); end
    total++; assert (last_out === 16'h0000) else begin bad++; $error("FAIL add_out got=%h exp=0000", last_out); end
    total++; assert ({last_co, last_v} === 2'b10) else begin bad++; $error("FAIL add_flags got=%b exp=10", {last_co, last_v}); end

    // Subtract with borrow/overflow
`ifdef PIPE_CLA_SAT_EN
    exp_sub = 16'h8000;
`else
    exp_sub = 16'h7FFF;
`endif
    a_step(1, 1, 1, 16'h8000, 16'h0001, 1);
    for (int i = 0; i < 5; i++) a_step(0, 0, 0, 16'h0, 16'h0, 1);
    total++; assert (last_out === exp_sub) else begin bad++; $error("FAIL sub_out got=%h exp=%h", last_out, exp_sub); end
    total++; assert ({last_co, last_v} === 2'b01) else begin bad++; $error("FAIL sub_flags got=%b exp=01", {last_co, last_v}); end

    // Back-to-back alternating stream
    p0 = a_pops;
    for (int i = 0; i < 8; i++) a_step(1, i[0], 0, 16'(i), 16'd3, 1);
    for (int i = 0; i < 5; i++) a_step(0, 0, 0, 16'h0, 16'h0, 1);
    total++; assert ((a_pops - p0) === 8) else begin bad++; $error("FAIL stream_count got=%0d exp=8", a_pops - p0); end
    lat_chk = 1'b0;

    // Backpressure with full pipe
    p0 = a_pops;
    for (int i = 0; i < 4; i++) a_step(1, 0, 1, 16'(16'h1000 + i), 16'h0101, 1);
    for (int i = 0; i < 5; i++) begin
      a_or = 1'b0;
      #1;
      total++; assert (a_ir === 1'b0) else begin bad++; $error("FAIL bp_in_ready got=%b exp=0", a_ir); end
      a_step(1, 1, 0, 16'($urandom), 16'($urandom), 0);
    end
    for (int i = 0; i < 10; i++) a_step(0, 0, 0, 16'h0, 16'h0, 1);
    total++; assert ((a_pops - p0) === 4) else begin bad++; $error("FAIL bp_count got=%0d exp=4", a_pops - p0); end
    total++; assert (qa.size() === 0) else begin bad++; $error("FAIL bp_left got=%0d exp=0", qa.size()); end

    // Reset mid-operation
    for (int i = 0; i < 3; i++) a_step(1, 0, 0, 16'h1234, 16'(16'h1111 + i), 1);
    a_step(0, 0, 0, 16'h0, 16'h0, 0);
    total++; assert (a_ov === 1'b1) else begin bad++; $error("FAIL pre_rst_valid got=%b exp=1", a_ov); end
    #2 rst = 1'b1;
    #1;
    total++; assert (a_ov === 1'b0) else begin bad++; $error("FAIL mid_rst_valid got=%b exp=0", a_ov); end
    total++; assert (a_out === 16'h0000) else begin bad++; $error("FAIL mid_rst_out got=%h exp=0000", a_out); end
    qa.delete();
    a_stalled = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; assert (a_ir === 1'b1) else begin bad++; $error("FAIL post_rst_ready got=%b exp=1", a_ir); end
    p0 = a_pops;
    for (int i = 0; i < 8; i++) a_step(0, 0, 0, 16'h0, 16'h0, 1);
    total++; assert ((a_pops - p0) === 0) else begin bad++; $error("FAIL post_rst_count got=%0d exp=0", a_pops - p0); end

    // Random mixed traffic, W=16
    for (int i = 0; i < 300; i++)
      a_step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3) != 0);
    for (int i = 0; i < 10; i++) a_step(0, 0, 0, 16'h0, 16'h0, 1);
    total++; assert (qa.size() === 0) else begin bad++; $error("FAIL a_rand_left got=%0d exp=0", qa.size()); end

    // Random stream, W=106 STAGES=3
    p0 = 0;
    while (p0 < 10000) begin
      logic iv;
      iv = $urandom_range(0, 7) != 0;
      b_step(iv, 1'($urandom), 1'($urandom), rand106(), rand106(), $urandom_range(0, 4) != 0);
      if (iv && b_ir) p0++;
    end
    for (int i = 0; i < 10; i++) b_step(0, 0, 0, '0, '0, 1);
    total++; assert (qb.size() === 0) else begin bad++; $error("FAIL b_rand_left got=%0d exp=0", qb.size()); end
    total++; assert (b_pops >= 10000) else begin bad++; $error("FAIL b_rand_count got=%0d exp>=10000", b_pops); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
